// File: rtl/coram_reader_pkg.sv
// Shared types and constants for the CoRAM input-stream reader.
package coram_reader_pkg;

    // Transfer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Depth of the output staging buffer, and the width of its occupancy count.
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BUF_CNT_W = 2;

    // Width of the output stall counter.
    localparam int unsigned STALL_W = 32;

endpackage

// File: rtl/coram_skid_fifo.sv
// Two-entry output staging buffer. The head entry drives the output directly.
// It does no flow control of its own: the caller never pushes into a full
// buffer unless it also pops, and never pops an empty one.
module coram_skid_fifo
    import coram_reader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [DATA_W-1:0]    i_data,
    output logic [DATA_W-1:0]    o_data,
    output logic [BUF_CNT_W-1:0] o_count
);

    localparam logic [BUF_CNT_W-1:0] CNT_ONE = {{(BUF_CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]    r_head;
    logic [DATA_W-1:0]    r_tail;
    logic [BUF_CNT_W-1:0] r_count;

    // Shift-style storage: the head is always the oldest word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + CNT_ONE;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - CNT_ONE;
                end
                2'b11: begin
                    if (r_count == CNT_ONE) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/coram_instream_reader.sv
// Reads LENGTH words from a FIFO-style input stream and presents them on a
// valid/ready output port, at up to one word per cycle.
// Optional feature: define CORAM_READER_STALL_COUNT_EN to build the output
// stall counter; otherwise STALL_COUNT is tied to zero.
module coram_instream_reader
    import coram_reader_pkg::*;
#(
    parameter int CORAM_DATA_WIDTH = 32,
    parameter int CORAM_LEN_WIDTH  = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic [CORAM_LEN_WIDTH-1:0]  LENGTH,
    output logic                        BUSY,
    output logic                        DONE,
    input  logic [CORAM_DATA_WIDTH-1:0] FIFO_Q,
    output logic                        FIFO_DEQ,
    input  logic                        FIFO_EMPTY,
    input  logic                        FIFO_ALM_EMPTY,
    output logic [CORAM_DATA_WIDTH-1:0] OUT_DATA,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic                        OUT_LAST,
    output logic [STALL_W-1:0]          STALL_COUNT
);

    localparam logic [CORAM_LEN_WIDTH-1:0] LEN_ONE =
        {{(CORAM_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CORAM_LEN_WIDTH-1:0]  r_rem_issue;
    logic [CORAM_LEN_WIDTH-1:0]  r_rem_accept;
    logic                        r_inflight;
    logic                        r_alm_block;
    logic                        r_done;

    logic                        w_deq;
    logic                        w_done_nxt;
    logic                        w_load;
    logic                        w_valid;
    logic                        w_pop;
    logic                        w_last;
    logic                        w_room;
    logic [2:0]                  w_occ;
    logic [BUF_CNT_W-1:0]        w_count;
    logic [CORAM_DATA_WIDTH-1:0] w_head;

    coram_skid_fifo #(
        .DATA_W (CORAM_DATA_WIDTH)
    ) u_buf (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (FIFO_Q),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & OUT_READY;
    assign w_last  = w_valid & (r_rem_accept == LEN_ONE);

    // Words already buffered plus the one on its way must leave a free slot,
    // counting the slot that a pop in this same cycle releases.
    assign w_occ  = 3'(w_count) + {2'b00, r_inflight};
    assign w_room = (w_occ < (DEPTH + {2'b00, w_pop}));

    assign w_load = (r_state == IDLE) & START & (LENGTH != '0);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, dequeue request and completion decision.
    always_comb begin
        w_state_nxt = r_state;
        w_deq       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    if (LENGTH != '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // The EMPTY flag lags a dequeue by a cycle, so after taking
                // what may have been the last word we hold off one cycle.
                w_deq = (r_rem_issue != '0) & ~FIFO_EMPTY & ~r_alm_block & w_room;
                if (w_deq && (r_rem_issue == LEN_ONE)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Issue and accept counters; loaded from LENGTH so the maximum length never wraps.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rem_issue  <= '0;
            r_rem_accept <= '0;
        end else if (w_load) begin
            r_rem_issue  <= LENGTH;
            r_rem_accept <= LENGTH;
        end else begin
            if (w_deq) begin
                r_rem_issue <= r_rem_issue - LEN_ONE;
            end
            if (w_pop) begin
                r_rem_accept <= r_rem_accept - LEN_ONE;
            end
        end
    end

    // Read-in-flight tracking, empty-lag guard and registered completion pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_inflight  <= 1'b0;
            r_alm_block <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight  <= w_deq;
            r_alm_block <= w_deq & FIFO_ALM_EMPTY;
            r_done      <= w_done_nxt;
        end
    end

`ifdef CORAM_READER_STALL_COUNT_EN
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
    logic [STALL_W-1:0] r_stall;

    // Saturating count of cycles where a word waits on the downstream.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stall <= '0;
        end else if (w_valid && !OUT_READY && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_ONE;
        end
    end

    assign STALL_COUNT = r_stall;
`else
    assign STALL_COUNT = '0;
`endif

    assign BUSY      = (r_state != IDLE);
    assign DONE      = r_done;
    assign FIFO_DEQ  = w_deq;
    assign OUT_DATA  = w_head;
    assign OUT_VALID = w_valid;
    assign OUT_LAST  = w_last;

endmodule

// File: tb/tb_coram_instream_reader.sv
// Self-checking bench for coram_instream_reader: a behavioural stream source,
// a transfer-level reference model and randomized handshake/refill stimulus.
module tb_coram_instream_reader;

    localparam int DW   = 32;
    localparam int LW   = 6;
    localparam int LMAX = (1 << LW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [LW-1:0] LENGTH = '0;
    logic          BUSY;
    logic          DONE;
    logic [DW-1:0] FIFO_Q = '0;
    logic          FIFO_DEQ;
    logic          FIFO_EMPTY = 1'b1;
    logic          FIFO_ALM_EMPTY = 1'b1;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          OUT_LAST;
    logic [31:0]   STALL_COUNT;

    coram_instream_reader #(
        .CORAM_DATA_WIDTH (DW),
        .CORAM_LEN_WIDTH  (LW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .LENGTH         (LENGTH),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .FIFO_Q         (FIFO_Q),
        .FIFO_DEQ       (FIFO_DEQ),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_ALM_EMPTY (FIFO_ALM_EMPTY),
        .OUT_DATA       (OUT_DATA),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .OUT_LAST       (OUT_LAST),
        .STALL_COUNT    (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream source: words waiting in the stream, and words handed out but not yet delivered.
    logic [DW-1:0] stream_q[$];
    logic [DW-1:0] exp_q[$];
    int            seq = 0;

    // Read data appears the cycle after a dequeue; EMPTY lags by one cycle,
    // ALM_EMPTY reflects the stream as it stands after the dequeue.
    always @(posedge CLK) begin
        FIFO_EMPTY <= (stream_q.size() == 0);
        if (FIFO_DEQ && stream_q.size() > 0)
            FIFO_ALM_EMPTY <= (stream_q.size() <= 2);
        else
            FIFO_ALM_EMPTY <= (stream_q.size() <= 1);
        if (FIFO_DEQ) begin
            if (stream_q.size() == 0) begin
                chk("phantom_deq", 64'(1), 64'(0));
            end else begin
                FIFO_Q <= stream_q[0];
                exp_q.push_back(stream_q[0]);
                void'(stream_q.pop_front());
            end
        end
    end

    // Reference model of the transfer.
    bit      m_active    = 1'b0;
    bit      m_done_pend = 1'b0;
    int      m_rem       = 0;
    int      m_len       = 0;
    int      m_issued    = 0;
    longint  m_stall     = 0;
    bit      prev_stall  = 1'b0;
    bit      prev_deq_alm = 1'b0;

    // Stimulus knobs and per-transfer observations.
    int rdy_mode    = 0;
    int refill_prob = 0;
    int pat_cnt     = 0;
    int cyc_n       = 0;
    int t0, first_deq, first_vld, done_cyc, last_hs, deq_cnt, hs_cnt;
    bit busy_seen;

    task automatic clr_ev();
        t0 = -1; first_deq = -1; first_vld = -1; done_cyc = -1; last_hs = -1;
        deq_cnt = 0; hs_cnt = 0; busy_seen = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        stream_q.push_back(w);
    endtask

    task automatic model_clear();
        m_active = 1'b0; m_done_pend = 1'b0; m_rem = 0; m_len = 0; m_issued = 0;
        m_stall = 0; prev_stall = 1'b0; prev_deq_alm = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step();
        logic [63:0] exp_stall;
        bit          hs;
        bit          done_nxt;
        bit          act_now;
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'($urandom_range(1));
            default: OUT_READY = ((pat_cnt % 3) == 0);
        endcase
        pat_cnt++;
        if (refill_prob > 0 && $urandom_range(99) < refill_prob && stream_q.size() < 8) begin
            seq++;
            push_word({8'($urandom), 24'(seq)});
        end
        #1;
        cyc_n++;
`ifdef CORAM_READER_STALL_COUNT_EN
        exp_stall = 64'(m_stall);
`else
        exp_stall = 64'(0);
`endif
        chk("busy", 64'(BUSY), 64'(m_active));
        chk("done", 64'(DONE), 64'(m_done_pend));
        chk("stall_count", 64'(STALL_COUNT), exp_stall);
        if (!m_active) begin
            chk("deq_idle", 64'(FIFO_DEQ), 64'(0));
            chk("valid_idle", 64'(OUT_VALID), 64'(0));
        end
        if (prev_stall) chk("valid_hold", 64'(OUT_VALID), 64'(1));
        if (prev_deq_alm) chk("deq_after_alm", 64'(FIFO_DEQ), 64'(0));
        if (OUT_VALID) begin
            if (exp_q.size() == 0) chk("phantom_word", 64'(1), 64'(0));
            else chk("data", 64'(OUT_DATA), 64'(exp_q[0]));
            chk("last", 64'(OUT_LAST), 64'(m_rem == 1));
        end else begin
            chk("last_novalid", 64'(OUT_LAST), 64'(0));
        end
        chk("occupancy", 64'(exp_q.size() <= 3), 64'(1));

        if (FIFO_DEQ && first_deq < 0) first_deq = cyc_n;
        if (OUT_VALID && first_vld < 0) first_vld = cyc_n;
        if (DONE && done_cyc < 0) done_cyc = cyc_n;
        if (BUSY) busy_seen = 1'b1;

        act_now  = m_active;
        done_nxt = 1'b0;
        hs       = OUT_VALID && OUT_READY;
        if (FIFO_DEQ) begin
            chk("deq_over_len", 64'(m_issued < m_len), 64'(1));
            m_issued++;
            deq_cnt++;
        end
        if (hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            last_hs = cyc_n;
            m_rem--;
            if (m_rem == 0) begin
                m_active = 1'b0;
                done_nxt = 1'b1;
            end
        end
        if (START && !act_now) begin
            t0 = cyc_n;
            if (LENGTH == '0) begin
                done_nxt = 1'b1;
            end else begin
                m_active = 1'b1;
                m_rem    = int'(LENGTH);
                m_len    = int'(LENGTH);
                m_issued = 0;
            end
        end
        if (OUT_VALID && !OUT_READY && m_stall < 64'hFFFF_FFFF) m_stall++;
        prev_stall   = OUT_VALID && !OUT_READY;
        prev_deq_alm = FIFO_DEQ && FIFO_ALM_EMPTY;
        m_done_pend  = done_nxt;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic start_xfer(input int len);
        clr_ev();
        START  = 1'b1;
        LENGTH = LW'(len);
        step();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while ((m_active || m_done_pend) && n < max_cyc) begin
            step();
            n++;
        end
        chk("xfer_timeout", 64'(m_active || m_done_pend), 64'(0));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_done", 64'(DONE), 64'(0));
        chk("rst_deq", 64'(FIFO_DEQ), 64'(0));
        chk("rst_valid", 64'(OUT_VALID), 64'(0));
        chk("rst_last", 64'(OUT_LAST), 64'(0));
        chk("rst_data", 64'(OUT_DATA), 64'(0));
        chk("rst_stall", 64'(STALL_COUNT), 64'(0));
    endtask

    // Called at a falling edge: assert reset, check outputs clear at once, release.
    task automatic do_reset();
        RST = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        #4;
        @(negedge CLK);
        idle_steps(2);
        RST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        clr_ev();
        #2 RST = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge CLK);
        idle_steps(2);
        RST = 1'b1;
        idle_steps(2);

        // Four-word transfer with the stream pre-filled and the sink always ready.
        rdy_mode = 0; refill_prob = 0;
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        idle_steps(3);
        start_xfer(4);
        run_until_idle(50);
        chk("r26_deq_lat", 64'(first_deq - t0), 64'(1));
        chk("r26_deq_cnt", 64'(deq_cnt), 64'(4));
        chk("r26_vld_lat", 64'(first_vld - t0), 64'(3));
        chk("r26_last_hs", 64'(last_hs - t0), 64'(6));
        chk("r26_done_lat", 64'(done_cyc - t0), 64'(7));
        chk("r26_words", 64'(hs_cnt), 64'(4));
        idle_steps(2);

        // Zero-length request completes immediately without touching the stream.
        push_word(32'h5555_0001);
        idle_steps(2);
        start_xfer(0);
        run_until_idle(10);
        idle_steps(3);
        chk("r27_done_lat", 64'(done_cyc - t0), 64'(1));
        chk("r27_busy_seen", 64'(busy_seen), 64'(0));
        chk("r27_deq_cnt", 64'(deq_cnt), 64'(0));
        void'(stream_q.pop_front());
        idle_steps(2);

        // A single word with a lagging EMPTY flag: only one dequeue, one word out.
        push_word(32'hC0DE_0001);
        idle_steps(3);
        start_xfer(2);
        idle_steps(6);
        chk("r29_deq_cnt", 64'(deq_cnt), 64'(1));
        chk("r29_words", 64'(hs_cnt), 64'(1));
        push_word(32'hC0DE_0002);
        run_until_idle(20);
        chk("r29_words_final", 64'(hs_cnt), 64'(2));
        idle_steps(2);

        // Eight words against a 1,0,0 ready pattern.
        rdy_mode = 2; pat_cnt = 0;
        for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + 32'(i));
        idle_steps(3);
        start_xfer(8);
        run_until_idle(100);
        chk("r28_words", 64'(hs_cnt), 64'(8));
        idle_steps(2);

        // START pulsed mid-transfer must not disturb the active one.
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) push_word(32'hDD00_0000 + 32'(i));
        idle_steps(3);
        start_xfer(3);
        step();
        START = 1'b1; LENGTH = LW'(5);
        step();
        run_until_idle(100);
        chk("r31_words", 64'(hs_cnt), 64'(3));
        chk("r31_done_seen", 64'(done_cyc >= 0), 64'(1));
        idle_steps(3);
        chk("r31_not_restarted", 64'(BUSY), 64'(0));
        stream_q.delete();
        idle_steps(2);

        // Reset in the middle of a six-word transfer, then a clean two-word one.
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) push_word(32'hE000_0000 + 32'(i));
        idle_steps(3);
        start_xfer(6);
        for (int i = 0; i < 20 && hs_cnt < 3; i++) step();
        chk("r30_pre_words", 64'(hs_cnt), 64'(3));
        clr_ev();
        do_reset();
        idle_steps(4);
        chk("r30_no_done", 64'(done_cyc < 0), 64'(1));
        stream_q.delete();
        push_word(32'hF000_0001);
        push_word(32'hF000_0002);
        idle_steps(3);
        start_xfer(2);
        run_until_idle(30);
        chk("r30_words", 64'(hs_cnt), 64'(2));
        chk("r30_done_seen", 64'(done_cyc >= 0), 64'(1));
        idle_steps(2);

        // Largest representable length, random ready and random refill.
        rdy_mode = 1; refill_prob = 70;
        start_xfer(LMAX);
        run_until_idle(2000);
        chk("max_words", 64'(hs_cnt), 64'(LMAX));
        refill_prob = 0;
        idle_steps(3);

        // Randomized transfers with stray STARTs while busy.
        for (int k = 0; k < 20; k++) begin
            int n;
            rdy_mode    = $urandom_range(2);
            refill_prob = $urandom_range(100, 30);
            len         = $urandom_range(20);
            start_xfer(len);
            n = 0;
            while ((m_active || m_done_pend) && n < 1000) begin
                if (m_active && $urandom_range(9) == 0) begin
                    START  = 1'b1;
                    LENGTH = LW'($urandom_range(LMAX));
                end
                step();
                n++;
            end
            chk("rnd_timeout", 64'(m_active || m_done_pend), 64'(0));
            chk("rnd_words", 64'(hs_cnt), 64'(len));
            chk("rnd_done_seen", 64'(done_cyc >= 0), 64'(1));
            idle_steps($urandom_range(3));
        end

        refill_prob = 0;
        idle_steps(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
